seq_divider: RTL and testbench

Multi-cycle unsigned integer divider, the inverse of the team's add/sub/multiply arithmetic units. It uses restoring shift-subtract, one quotient bit per clock. It sits beside the arithmetic block as the divide path, with a start/busy/done handshake to its controller. It also reports divide-by-zero.

---
 rtl/seq_divider_if.sv | 21 ++
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the divide controller and seq_divider.
interface seq_divider_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider: one quotient bit per clock, WIDTH cycles per result,
// with a one-cycle divide-by-zero shortcut.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   q_r, d_r, r_r;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   quotient_r, remainder_r;
    logic               dbz_r;

    logic [WIDTH:0]     r_shift;
    logic [WIDTH-1:0]   q_nxt, r_nxt;
    logic               last;

    // The WIDTH+1-bit partial remainder only exists transiently in r_shift; after the
    // conditional subtract it is always below the divisor, so WIDTH bits are stored.
    always_comb begin
        r_shift = {r_r, q_r[WIDTH-1]};
        q_nxt   = {q_r[WIDTH-2:0], 1'b0};
        r_nxt   = r_shift[WIDTH-1:0];
        if (r_shift >= {1'b0, d_r}) begin
            r_nxt = r_shift[WIDTH-1:0] - d_r;
            q_nxt = {q_r[WIDTH-2:0], 1'b1};
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r         <= '0;
            r_r         <= '0;
            d_r         <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                        end else begin
                            q_r <= bus.dividend;
                            r_r <= '0;
                            d_r <= bus.divisor;
                            cnt <= '0;
                        end
                    end
                end
                RUN: begin
                    q_r <= q_nxt;
                    r_r <= r_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        quotient_r  <= q_nxt;
                        remainder_r <= r_nxt;
                        dbz_r       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive bench for the 4-bit seq_divider: vector table, multi-cycle corner
// sequences (ignored restart, asynchronous abort) and a back-to-back sweep of all operand pairs.
module tb_seq_divider;
    logic clk;
    logic reset;

    seq_divider_if #(.WIDTH(4)) bus ();

    seq_divider #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         edges;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Starts one division and waits (bounded) for done. edges = clock edges after the start
    // edge before done is seen; busyc = cycles with busy high up to and including the done cycle.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           output int q, output int r, output int z,
                           output int edges, output int busyc, output bit ok);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        edges = 0; busyc = 0; ok = 1'b0; q = -1; r = -1; z = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busyc++;
            if (bus.done) begin
                ok = 1'b1;
                q  = int'(bus.quotient);
                r  = int'(bus.remainder);
                z  = int'(bus.div_by_zero);
                break;
            end
            edges++;
        end
        if (!ok) chk($sformatf("timeout %0d/%0d", a, b), 0, 1);
    endtask

    int q, r, z, edges, busyc, dones;
    bit ok;

    initial begin
        vecs[0] = '{a: 4'd5,  b: 4'd9,  q: 4'd0,  r: 4'd5, z: 1'b0, edges: 4};
        vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0, edges: 4};
        vecs[2] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0, edges: 4};
        vecs[3] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, z: 1'b1, edges: 0};
        vecs[4] = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, z: 1'b0, edges: 4};
        vecs[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0, edges: 4};
        vecs[6] = '{a: 4'd14, b: 4'd4,  q: 4'd3,  r: 4'd2, z: 1'b0, edges: 4};
        vecs[7] = '{a: 4'd11, b: 4'd8,  q: 4'd1,  r: 4'd3, z: 1'b0, edges: 4};

        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset quotient", int'(bus.quotient), 0);
        chk("reset remainder", int'(bus.remainder), 0);
        chk("reset div_by_zero", int'(bus.div_by_zero), 0);
        reset = 1'b0;

        // 13/3: latency, busy window, and single-cycle done
        run_div(4'd13, 4'd3, q, r, z, edges, busyc, ok);
        chk("13/3 quotient", q, 4);
        chk("13/3 remainder", r, 1);
        chk("13/3 div_by_zero", z, 0);
        chk("13/3 latency", edges, 4);
        chk("13/3 busy cycles", busyc, 5);
        @(negedge clk);
        chk("13/3 done drops", int'(bus.done), 0);
        chk("13/3 busy drops", int'(bus.busy), 0);
        chk("13/3 quotient holds", int'(bus.quotient), 4);

        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].a, vecs[i].b, q, r, z, edges, busyc, ok);
            chk($sformatf("vec%0d %0d/%0d quotient", i, vecs[i].a, vecs[i].b), q, int'(vecs[i].q));
            chk($sformatf("vec%0d %0d/%0d remainder", i, vecs[i].a, vecs[i].b), r, int'(vecs[i].r));
            chk($sformatf("vec%0d %0d/%0d div_by_zero", i, vecs[i].a, vecs[i].b), z, int'(vecs[i].z));
            chk($sformatf("vec%0d %0d/%0d latency", i, vecs[i].a, vecs[i].b), edges, vecs[i].edges);
        end

        // Second start two cycles into RUN with new operands must be ignored
        @(negedge clk);
        bus.dividend = 4'd12; bus.divisor = 4'd5; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.dividend = 4'd3; bus.divisor = 4'd1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dones = 0; q = -1; r = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                q = int'(bus.quotient);
                r = int'(bus.remainder);
            end
        end
        chk("restart ignored done pulses", dones, 1);
        chk("restart ignored quotient", q, 2);
        chk("restart ignored remainder", r, 2);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        bus.dividend = 4'd14; bus.divisor = 4'd4; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort done", int'(bus.done), 0);
        chk("abort quotient", int'(bus.quotient), 0);
        chk("abort remainder", int'(bus.remainder), 0);
        chk("abort div_by_zero", int'(bus.div_by_zero), 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("abort no done after release", dones, 0);
        run_div(4'd9, 4'd2, q, r, z, edges, busyc, ok);
        chk("9/2 quotient", q, 4);
        chk("9/2 remainder", r, 1);
        chk("9/2 div_by_zero", z, 0);

        // Exhaustive back-to-back sweep: each start lands in the first IDLE cycle after DONE
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int eq, er, ez, el;
                if (b == 0) begin
                    eq = 15; er = a; ez = 1; el = 0;
                end else begin
                    eq = a / b; er = a % b; ez = 0; el = 4;
                end
                run_div(4'(a), 4'(b), q, r, z, edges, busyc, ok);
                chk($sformatf("sweep %0d/%0d quotient", a, b), q, eq);
                chk($sformatf("sweep %0d/%0d remainder", a, b), r, er);
                chk($sformatf("sweep %0d/%0d div_by_zero", a, b), z, ez);
                chk($sformatf("sweep %0d/%0d latency", a, b), edges, el);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
